// File: rtl/vending_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int COIN_SMALL_VAL = 1;

  function automatic int price(input int idx, input int step);
    return (idx + 1) * step;
  endfunction

endpackage

// File: rtl/vending_input_sync.sv
// N-bit two-flop synchroniser followed by rising-edge detection; rise is a
// one-cycle event aligned to the synchronised level.
module vending_input_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] rise
);

  logic [N-1:0] meta_q, meta_d;
  logic [N-1:0] sync_q, sync_d;
  logic [N-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit, priced product vend, change return.
// Define VENDING_KEEP_CREDIT_EN to keep leftover credit after a vend instead of refunding it.
//
// state  | meaning
// IDLE   | accepting coins, buy and cancel
// VEND   | dispense held high, counted down by disp_cnt
// CHANGE | returning credit one unit per cycle
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int CREDIT_W     = 5,
  parameter int MAX_CREDIT   = 31,
  parameter int COIN_LARGE   = 5,
  parameter int NUM_PRODUCTS = 4,
  parameter int PRICE_STEP   = 3,
  parameter int DISP_CYCLES  = 4,
  localparam int SEL_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_small,
  input  logic                coin_large,
  input  logic                buy,
  input  logic                cancel,
  input  logic [SEL_W-1:0]    sel,
  output logic                dispense,
  output logic [SEL_W-1:0]    product,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                busy
);

  localparam int CW1    = CREDIT_W + 1;
  localparam int DCW    = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES + 1) : 1;
  localparam int N_SLOT = 2 ** SEL_W;

  logic [3:0] ev;
  logic       ev_small, ev_large, ev_buy, ev_cancel;

  vending_input_sync #(.N(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({cancel, buy, coin_large, coin_small}),
    .rise  (ev)
  );

  assign {ev_cancel, ev_buy, ev_large, ev_small} = ev;

  // Select codes past NUM_PRODUCTS map to invalid slots and read as unaffordable.
  logic [CW1-1:0] price_tbl [N_SLOT];
  logic           valid_tbl [N_SLOT];

  for (genvar i = 0; i < N_SLOT; i++) begin : g_price
    assign price_tbl[i] = (i < NUM_PRODUCTS) ? CW1'(price(i, PRICE_STEP)) : '0;
    assign valid_tbl[i] = (i < NUM_PRODUCTS);
  end

  state_t             state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [DCW-1:0]      disp_cnt_q, disp_cnt_d;
  logic                dispense_q, dispense_d;
  logic [SEL_W-1:0]    product_q, product_d;
  logic                change_pulse_q, change_pulse_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;
  logic                busy_q, busy_d;

  logic [CW1-1:0] credit_ext, sum_small, sum_large, sel_price, after_buy;
  logic           sel_valid;

  assign credit_ext = {1'b0, credit_q};
  assign sum_small  = credit_ext + CW1'(COIN_SMALL_VAL);
  assign sum_large  = credit_ext + CW1'(COIN_LARGE);
  assign sel_price  = price_tbl[sel];
  assign sel_valid  = valid_tbl[sel];
  assign after_buy  = credit_ext - sel_price;

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    disp_cnt_d     = disp_cnt_q;
    dispense_d     = dispense_q;
    product_d      = product_q;
    change_pulse_d = 1'b0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev_cancel) begin
          coin_reject_d = ev_small | ev_large;
          if (credit_q != '0) state_d = CHANGE;
        end else if (ev_buy) begin
          coin_reject_d = ev_small | ev_large;
          if (sel_valid && (credit_ext >= sel_price)) begin
            credit_d   = after_buy[CREDIT_W-1:0];
            product_d  = sel;
            dispense_d = 1'b1;
            disp_cnt_d = DCW'(DISP_CYCLES - 1);
            state_d    = VEND;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (ev_large) begin
          coin_reject_d = ev_small;
          if (sum_large <= CW1'(MAX_CREDIT)) credit_d = sum_large[CREDIT_W-1:0];
          else                               coin_reject_d = 1'b1;
        end else if (ev_small) begin
          if (sum_small <= CW1'(MAX_CREDIT)) credit_d = sum_small[CREDIT_W-1:0];
          else                               coin_reject_d = 1'b1;
        end
      end

      VEND: begin
        coin_reject_d = ev_small | ev_large;
        if (disp_cnt_q == '0) begin
          dispense_d = 1'b0;
`ifdef VENDING_KEEP_CREDIT_EN
          state_d = IDLE;
`else
          state_d = (credit_q != '0) ? CHANGE : IDLE;
`endif
        end else begin
          disp_cnt_d = disp_cnt_q - DCW'(1);
        end
      end

      CHANGE: begin
        coin_reject_d = ev_small | ev_large;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          change_pulse_d = 1'b1;
          credit_d       = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      disp_cnt_q     <= '0;
      dispense_q     <= 1'b0;
      product_q      <= '0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      disp_cnt_q     <= disp_cnt_d;
      dispense_q     <= dispense_d;
      product_q      <= product_d;
      change_pulse_q <= change_pulse_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      busy_q         <= busy_d;
    end
  end

  assign dispense     = dispense_q;
  assign product      = product_q;
  assign change_pulse = change_pulse_q;
  assign credit       = credit_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed self-checking bench for vending_fsm_param with default parameters.
module tb_vending_fsm_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_small = 1'b0, coin_large = 1'b0, buy = 1'b0, cancel = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       dispense, change_pulse, coin_reject, insufficient, busy;
  logic [1:0] product;
  logic [4:0] credit;

  int total = 0;
  int bad   = 0;
  int n_disp, n_chg;

  vending_fsm_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_small   (coin_small),
    .coin_large   (coin_large),
    .buy          (buy),
    .cancel       (cancel),
    .sel          (sel),
    .dispense     (dispense),
    .product      (product),
    .change_pulse (change_pulse),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise pins {cancel,buy,large,small}; return just after the edge where the event acts.
  task automatic evt(input logic [3:0] m);
    {cancel, buy, coin_large, coin_small} = m;
    repeat (3) tick();
  endtask

  task automatic rel(input int n);
    {cancel, buy, coin_large, coin_small} = 4'b0000;
    repeat (n) tick();
  endtask

  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      n_disp += int'(dispense);
      n_chg  += int'(change_pulse);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_dispense", dispense, 0);
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_change", change_pulse, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_credit", credit, 0);

    // small, small, large, buy sel=1
    evt(4'b0001); chk("t2_cred1", credit, 1); rel(3);
    evt(4'b0001); chk("t2_cred2", credit, 2); rel(3);
    evt(4'b0010); chk("t2_cred7", credit, 7); rel(3);
    sel = 2'd1;
    evt(4'b0100);
    chk("t2_dispense", dispense, 1);
    chk("t2_product", product, 1);
    chk("t2_cred_after", credit, 1);
    chk("t2_busy", busy, 1);
    n_disp = int'(dispense); n_chg = 0;
    buy = 1'b0;
    watch(10);
    chk("t2_disp_cycles", n_disp, 4);
    chk("t2_chg_count", n_chg, 1);
    chk("t2_cred_end", credit, 0);
    chk("t2_busy_end", busy, 0);
    chk("t2_chg_low", change_pulse, 0);
    rel(3);

    // insufficient credit
    evt(4'b0001); rel(3);
    evt(4'b0001); rel(3);
    sel = 2'd0;
    evt(4'b0100);
    chk("t3_insuff", insufficient, 1);
    chk("t3_credit", credit, 2);
    chk("t3_dispense", dispense, 0);
    tick();
    chk("t3_insuff_once", insufficient, 0);
    rel(3);
    evt(4'b1000); rel(6);
    chk("t3_clean", credit, 0);

    // saturation at MAX_CREDIT
    for (int i = 0; i < 6; i++) begin evt(4'b0010); rel(3); end
    chk("t4_cred30", credit, 30);
    evt(4'b0010);
    chk("t4_reject", coin_reject, 1);
    chk("t4_cred_hold", credit, 30);
    rel(3);
    chk("t4_reject_low", coin_reject, 0);
    evt(4'b0001);
    chk("t4_cred31", credit, 31);
    rel(3);
    evt(4'b1000); rel(36);
    chk("t4_clean", credit, 0);

    // cancel with coin during CHANGE
    evt(4'b0010); rel(3);
    evt(4'b1000);
    chk("t5_cred_enter", credit, 5);
    chk("t5_busy", busy, 1);
    cancel = 1'b0;
    coin_small = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t5_cred_%0d", k), credit, 4 - k);
      chk($sformatf("t5_pulse_%0d", k), change_pulse, 1);
      if (k == 2) chk("t5_coin_reject", coin_reject, 1);
    end
    tick();
    chk("t5_pulse_end", change_pulse, 0);
    chk("t5_busy_end", busy, 0);
    chk("t5_cred_end", credit, 0);
    rel(3);

    // buy and cancel together: cancel wins
    evt(4'b0010); rel(3);
    for (int i = 0; i < 4; i++) begin evt(4'b0001); rel(3); end
    chk("t6_cred9", credit, 9);
    sel = 2'd0;
    evt(4'b1100);
    n_disp = int'(dispense); n_chg = 0;
    {cancel, buy} = 2'b00;
    watch(15);
    chk("t6_no_disp", n_disp, 0);
    chk("t6_chg9", n_chg, 9);
    chk("t6_cred_end", credit, 0);
    rel(3);

    // leftover credit after vend: kept or refunded depending on build
    evt(4'b0010); rel(3);
    evt(4'b0001); rel(3);
    evt(4'b0001); rel(3);
    sel = 2'd0;
    evt(4'b0100);
    chk("t7_dispense", dispense, 1);
    chk("t7_cred4", credit, 4);
    n_disp = int'(dispense); n_chg = 0;
    buy = 1'b0;
    watch(12);
    chk("t7_disp_cycles", n_disp, 4);
    chk("t7_busy_end", busy, 0);
`ifdef VENDING_KEEP_CREDIT_EN
    chk("t7_no_chg", n_chg, 0);
    chk("t7_kept", credit, 4);
    evt(4'b1000); rel(8);
`else
    chk("t7_chg4", n_chg, 4);
    chk("t7_cred0", credit, 0);
`endif
    rel(3);

    // asynchronous reset in the middle of a vend
    for (int i = 0; i < 3; i++) begin evt(4'b0001); rel(3); end
    sel = 2'd0;
    evt(4'b0100);
    buy = 1'b0;
    tick();
    chk("t1_pre_disp", dispense, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_async_disp", dispense, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_credit", credit, 0);
    #2 rst_n = 1'b1;
    repeat (2) tick();
    chk("t1_idle_credit", credit, 0);
    chk("t1_idle_busy", busy, 0);
    evt(4'b0001);
    chk("t1_after_coin", credit, 1);
    rel(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
